// File: rtl/branch_pc_unit.sv
// ============================================================================
// branch_pc_unit : branch resolution, target generation and fetch PC register
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_pc_unit #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    CONTROL_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     br_valid,
  input  logic [2:0]               br_type,
  input  logic [DATA_WIDTH-1:0]    br_pc,
  input  logic [DATA_WIDTH-1:0]    br_offset,
  input  logic [CONTROL_WIDTH-1:0] branch,
  input  logic                     operands_ready,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     flush,
  output logic                     br_stall,
  output logic [7:0]               taken_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic                    flush_q, flush_d;
  logic [7:0]              taken_count_q, taken_count_d;
  logic                    taken;
  logic [DATA_WIDTH-1:0]   target;

  // Relation code 11 (no relation) matches none of the conditional cases.
  always_comb begin
    taken = 1'b0;
    case (br_type)
      3'b000:  taken = (branch == 2'b10);
      3'b001:  taken = (branch == 2'b00) || (branch == 2'b01);
      3'b010:  taken = (branch == 2'b00);
      3'b011:  taken = (branch == 2'b01);
      3'b100:  taken = (branch == 2'b00) || (branch == 2'b10);
      3'b101:  taken = (branch == 2'b01) || (branch == 2'b10);
      3'b110:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign target = br_pc + PC_ONE + br_offset;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = flush_q;
    taken_count_d = taken_count_q;
    if (!stall) begin
      if (state_q == FLUSH) begin
        // Whatever sits in decode now is wrong-path; just advance fetch.
        pc_d    = pc_q + PC_ONE;
        flush_d = 1'b0;
        state_d = IDLE;
      end else if (br_valid && operands_ready) begin
        if (taken) begin
          pc_d    = target;
          flush_d = 1'b1;
          state_d = FLUSH;
          if (taken_count_q != 8'hFF) taken_count_d = taken_count_q + 8'd1;
        end else begin
          pc_d    = pc_q + PC_ONE;
          flush_d = 1'b0;
          state_d = IDLE;
        end
      end else if (br_valid) begin
        flush_d = 1'b0;
        state_d = WAIT_OPS;
      end else begin
        pc_d    = pc_q + PC_ONE;
        flush_d = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      taken_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign pc          = pc_q;
  assign flush       = flush_q;
  assign taken_count = taken_count_q;
  assign br_stall    = br_valid & ~operands_ready & (state_q != FLUSH) & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
// Directed, table-driven bench for branch_pc_unit.
`default_nettype none

module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, br_valid, operands_ready;
  logic [2:0]  br_type;
  logic [15:0] br_pc, br_offset;
  logic [1:0]  branch;
  logic [15:0] pc;
  logic        flush, br_stall;
  logic [7:0]  taken_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_pc;
  logic [7:0]  exp_cnt;

  typedef struct {
    logic [2:0]  typ;
    logic [1:0]  code;
    logic [15:0] bpc;
    logic [15:0] off;
    logic        taken;
    logic [15:0] tgt;
  } vec_t;
  vec_t vecs[$];

  branch_pc_unit #(.DATA_WIDTH(16), .CONTROL_WIDTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_type(br_type),
    .br_pc(br_pc), .br_offset(br_offset), .branch(branch),
    .operands_ready(operands_ready), .pc(pc), .flush(flush),
    .br_stall(br_stall), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_br(input logic [2:0] t, input logic [1:0] c,
                          input logic [15:0] bp, input logic [15:0] of, input logic rdy);
    br_valid = 1'b1; br_type = t; branch = c; br_pc = bp; br_offset = of;
    operands_ready = rdy;
  endtask

  task automatic idle_in();
    br_valid = 1'b0; operands_ready = 1'b1; br_type = 3'b000; branch = 2'b11;
    br_pc = 16'h0; br_offset = 16'h0;
  endtask

  initial begin
    // BEQ..JMP/reserved against each relation code; expected targets by hand.
    vecs.push_back('{3'b000, 2'b10, 16'h0100, 16'h0004, 1'b1, 16'h0105});
    vecs.push_back('{3'b000, 2'b00, 16'h0100, 16'h0004, 1'b0, 16'h0000});
    vecs.push_back('{3'b001, 2'b00, 16'h0200, 16'h0010, 1'b1, 16'h0211});
    vecs.push_back('{3'b001, 2'b01, 16'h0200, 16'hFFFF, 1'b1, 16'h0200});
    vecs.push_back('{3'b001, 2'b10, 16'h0200, 16'h0010, 1'b0, 16'h0000});
    vecs.push_back('{3'b010, 2'b00, 16'h0300, 16'hFFF0, 1'b1, 16'h02F1});
    vecs.push_back('{3'b010, 2'b01, 16'h0300, 16'hFFF0, 1'b0, 16'h0000});
    vecs.push_back('{3'b011, 2'b01, 16'h0400, 16'h0000, 1'b1, 16'h0401});
    vecs.push_back('{3'b011, 2'b00, 16'h0400, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{3'b100, 2'b00, 16'h0500, 16'h0002, 1'b1, 16'h0503});
    vecs.push_back('{3'b100, 2'b10, 16'h0500, 16'h0020, 1'b1, 16'h0521});
    vecs.push_back('{3'b100, 2'b01, 16'h0500, 16'h0020, 1'b0, 16'h0000});
    vecs.push_back('{3'b101, 2'b01, 16'h0600, 16'h0100, 1'b1, 16'h0701});
    vecs.push_back('{3'b101, 2'b10, 16'h0600, 16'h8000, 1'b1, 16'h8601});
    vecs.push_back('{3'b101, 2'b00, 16'h0600, 16'h8000, 1'b0, 16'h0000});
    vecs.push_back('{3'b110, 2'b11, 16'h0700, 16'h0007, 1'b1, 16'h0708});
    vecs.push_back('{3'b111, 2'b10, 16'h0700, 16'h0007, 1'b0, 16'h0000});
    vecs.push_back('{3'b111, 2'b00, 16'h0700, 16'h0007, 1'b0, 16'h0000});
    vecs.push_back('{3'b000, 2'b11, 16'h0800, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{3'b001, 2'b11, 16'h0800, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{3'b010, 2'b11, 16'h0800, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{3'b011, 2'b11, 16'h0800, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{3'b100, 2'b11, 16'h0800, 16'h0001, 1'b0, 16'h0000});
    vecs.push_back('{3'b101, 2'b11, 16'h0800, 16'h0001, 1'b0, 16'h0000});

    // Reset, with a pending branch to show br_stall is masked by rst.
    rst = 1'b1; stall = 1'b0;
    drive_br(3'b000, 2'b10, 16'h0, 16'h0, 1'b0);
    step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_flush", flush, 0);
    chk("rst_count", taken_count, 0);
    chk("rst_br_stall", br_stall, 0);
    rst = 1'b0; idle_in();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("idle_pc%0d", i), pc, i);
      chk($sformatf("idle_flush%0d", i), flush, 0);
    end
    exp_pc = 16'h0004; exp_cnt = 8'd0;

    // BEQ taken; a branch presented during FLUSH must be discarded.
    drive_br(3'b000, 2'b10, 16'h0010, 16'h0005, 1'b1);
    step();
    chk("beq_pc", pc, 16'h0016);
    chk("beq_flush", flush, 1);
    chk("beq_count", taken_count, 1);
    drive_br(3'b110, 2'b11, 16'h1000, 16'h0000, 1'b0);
    #1 chk("flush_br_stall", br_stall, 0);
    operands_ready = 1'b1;
    step();
    chk("beq_post_pc", pc, 16'h0017);
    chk("beq_post_flush", flush, 0);
    chk("beq_post_count", taken_count, 1);
    exp_pc = 16'h0017; exp_cnt = 8'd1;

    // Table of branch types against relation codes.
    foreach (vecs[k]) begin
      drive_br(vecs[k].typ, vecs[k].code, vecs[k].bpc, vecs[k].off, 1'b1);
      step();
      if (vecs[k].taken) begin
        exp_pc = vecs[k].tgt; exp_cnt = exp_cnt + 8'd1;
      end else begin
        exp_pc = exp_pc + 16'd1;
      end
      chk($sformatf("vec%0d_pc", k), pc, exp_pc);
      chk($sformatf("vec%0d_flush", k), flush, vecs[k].taken);
      chk($sformatf("vec%0d_count", k), taken_count, exp_cnt);
      if (vecs[k].taken) begin
        idle_in();
        step();
        exp_pc = exp_pc + 16'd1;
        chk($sformatf("vec%0d_exit_pc", k), pc, exp_pc);
        chk($sformatf("vec%0d_exit_flush", k), flush, 0);
      end
    end

    // BGE waiting three cycles on forwarded operands.
    drive_br(3'b101, 2'b10, 16'h0040, 16'h0008, 1'b0);
    #1 chk("wait_br_stall0", br_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait_pc%0d", i), pc, exp_pc);
      chk($sformatf("wait_br_stall%0d", i + 1), br_stall, 1);
      chk($sformatf("wait_flush%0d", i), flush, 0);
    end
    operands_ready = 1'b1;
    #1 chk("wait_ready_br_stall", br_stall, 0);
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("wait_target", pc, 16'h0049);
    chk("wait_flush", flush, 1);
    idle_in(); step();
    chk("wait_exit_pc", pc, 16'h004A);
    exp_pc = 16'h004A;

    // stall defers a resolve event sitting in IDLE.
    stall = 1'b1;
    drive_br(3'b110, 2'b11, 16'h0020, 16'h0000, 1'b1);
    step();
    chk("defer_pc", pc, exp_pc);
    chk("defer_flush", flush, 0);
    chk("defer_count", taken_count, exp_cnt);
    stall = 1'b0;
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("defer_target", pc, 16'h0021);
    chk("defer_count2", taken_count, exp_cnt);
    idle_in(); step();

    // JMP wrapping the 16-bit PC, then stall held through FLUSH.
    drive_br(3'b110, 2'b11, 16'hFFFE, 16'h0003, 1'b1);
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("wrap_pc", pc, 16'h0002);
    chk("wrap_flush", flush, 1);
    stall = 1'b1; idle_in();
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("fstall_pc%0d", i), pc, 16'h0002);
      chk($sformatf("fstall_flush%0d", i), flush, 1);
      chk($sformatf("fstall_count%0d", i), taken_count, exp_cnt);
    end
    stall = 1'b0;
    step();
    chk("fstall_exit_pc", pc, 16'h0003);
    chk("fstall_exit_flush", flush, 0);

    // Saturation of the taken counter.
    for (int i = 0; i < 300; i++) begin
      drive_br(3'b110, 2'b11, 16'h0200, 16'h0000, 1'b1);
      step();
      idle_in();
      step();
    end
    chk("sat_count", taken_count, 255);
    chk("sat_pc", pc, 16'h0202);

    // Reset arriving mid-FLUSH.
    drive_br(3'b110, 2'b11, 16'h0300, 16'h0010, 1'b1);
    step();
    chk("pre_rst_flush", flush, 1);
    chk("pre_rst_pc", pc, 16'h0311);
    rst = 1'b1; stall = 1'b1;
    step();
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_flush", flush, 0);
    chk("midrst_count", taken_count, 0);
    rst = 1'b0; stall = 1'b0; idle_in();
    step();
    chk("post_rst_pc", pc, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_pc_unit.md
# branch_pc_unit

Branch-resolution and program-counter stage fed directly by the branch comparator. It combines the comparator's 2-bit relation code with the decoded branch type to decide taken/not-taken. It computes the target and owns the fetch PC register. It also raises a one-cycle flush of the wrong-path instruction and stalls fetch while branch operands are still being forwarded.

## Interface
- DATA_WIDTH, 16, width of PC, offset and branch PC
- CONTROL_WIDTH, 2, width of comparator relation code
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  DATA_WIDTH-independent 1  pipeline-wide hold; PC and state frozen
- br_valid  in  1  decode stage holds a branch/jump instruction
- br_type  in  3  000 BEQ, 001 BNE, 010 BLT, 011 BGT, 100 BLE, 101 BGE, 110 JMP, 111 reserved
- br_pc  in  DATA_WIDTH  PC of the branch instruction
- br_offset  in  DATA_WIDTH  signed word offset
- branch  in  CONTROL_WIDTH  comparator code: 00 less, 01 greater, 10 equal, 11 none
- operands_ready  in  1  compared operands are final (forwarding resolved)
- pc  out  DATA_WIDTH  registered fetch PC
- flush  out  1  registered; squash IF/ID contents
- br_stall  out  1  combinational; hold fetch/decode while waiting for operands
- taken_count  out  8  registered saturating count of taken branches/jumps

## Operation
- States: IDLE, WAIT_OPS, FLUSH.
- Taken condition:
  - BEQ: code 10. BNE: code 00 or 01. BLT: 00. BGT: 01. BLE: 00 or 10. BGE: 01 or 10.
  - JMP: always taken.
  - Reserved: never taken.
  - Code 11: not taken for every conditional type.
- Target = br_pc + 1 + br_offset, modulo 2^DATA_WIDTH (wraps, no overflow flag).
- Resolve event: state IDLE or WAIT_OPS, br_valid=1, operands_ready=1, stall=0.
- In IDLE or WAIT_OPS with no resolve event and stall=0:
  - br_valid=1, operands_ready=0: go to WAIT_OPS, pc held.
  - br_valid=0: pc <= pc+1, go to IDLE (a WAIT_OPS with br_valid dropped returns to IDLE).
- On a resolve event:
  - Taken: pc <= target, flush <= 1, taken_count += 1 (saturates at 255), go to FLUSH.
  - Not taken: pc <= pc+1, flush <= 0, go to IDLE.
- FLUSH state:
  - br_valid is ignored (the instruction is wrong-path).
  - stall=0: pc <= pc+1, flush <= 0, go to IDLE.
  - stall=1: everything held, flush stays 1.
- br_stall = br_valid & ~operands_ready & (state≠FLUSH) & ~rst.
- stall=1 in any state: pc, state, flush and taken_count all hold. stall has priority over a resolve event, which is deferred.

## Timing
- Reset (rst high at an edge): pc=RESET_PC, flush=0, taken_count=0, state=IDLE. br_stall is 0 while rst is high.
- rst overrides all other inputs, including mid-FLUSH and WAIT_OPS; flush drops at that edge.
- Resolve latency: target visible on pc, and flush=1, one cycle after the resolve edge. flush is high for exactly one cycle when stall=0.
- A not-taken branch costs zero extra cycles.
- Each cycle spent waiting on operands adds one cycle, during which pc is held and br_stall=1.
- Back-to-back branches: a branch presented during FLUSH is discarded. The next branch can resolve in the cycle after FLUSH.
- Inputs are sampled only at rising clk edges. br_stall is the only combinational output.

## Test plan
- Reset, then 4 idle cycles with RESET_PC=0 -> pc sequence 0,1,2,3,4; flush=0; taken_count=0.
- BEQ with br_pc=0x0010, offset=0x0005, branch=10, ready=1 -> next cycle pc=0x0016, flush=1 for one cycle, then pc=0x0017, taken_count=1.
- BLT with branch=01 (greater) -> not taken: pc increments, flush stays 0. Repeat with branch=11 for all six conditional types -> never taken.
- BGE with operands_ready low for 3 cycles, then high with branch=10 -> br_stall=1 and pc held for 3 cycles; target loaded on the 4th edge.
- JMP with br_pc=0xFFFE, offset=0x0003 -> pc wraps to 0x0002. Assert stall during FLUSH for 2 cycles -> flush held high, pc frozen at 0x0002.
- 300 consecutive taken JMPs -> taken_count saturates at 255. Assert rst mid-FLUSH -> pc=RESET_PC, flush=0, taken_count=0 at the next edge.
